div_36x36_frac: RTL and testbench

// - Sequential unsigned divider that fractures like the 36-bit fracturable multiplier. It runs as

---
 rtl/div_frac_pkg.sv | 19 +
 rtl/frac_sub_36.sv | 35 +++
 rtl/div_36x36_frac.sv | 111 +++++++++++
 tb/tb_div_36x36_frac.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/div_frac_pkg.sv
// div_frac_pkg: shared widths, mode encoding, FSM states and lane helpers for the fracturable divider.
package div_frac_pkg;
    localparam int DW   = 36;
    localparam int LW9  = DW / 4;
    localparam int LW18 = DW / 2;
    localparam logic [1:0] MODE_4X9  = 2'b01;
    localparam logic [1:0] MODE_2X18 = 2'b10;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    function automatic logic [5:0] iter_count(input logic [1:0] mode);
        return (mode == MODE_4X9) ? 6'(LW9) : (mode == MODE_2X18) ? 6'(LW18) : 6'(DW);
    endfunction
    // Bit index 0 is the MSB; lanes are numbered from the MSB end.
    function automatic logic [1:0] lane_of(input logic [1:0] mode, input int i);
        return (mode == MODE_4X9) ? 2'(i / LW9) : (mode == MODE_2X18) ? 2'(i / LW18) : 2'd0;
    endfunction
    function automatic logic is_lsb(input logic [1:0] mode, input int i);
        return (mode == MODE_4X9) ? (i % LW9 == LW9 - 1) : (mode == MODE_2X18) ? (i % LW18 == LW18 - 1) : (i == DW - 1);
    endfunction
endpackage

// File: rtl/frac_sub_36.sv
// frac_sub_36: per-lane (W+1)-bit subtractor built from 9-bit chunks with borrow cuts at lane boundaries.
module frac_sub_36
    import div_frac_pkg::*;
(
    input  logic [1:0]    mode_i,
    input  logic [0:DW-1] a_i,
    input  logic [0:3]    a_top_i,
    input  logic [0:DW-1] b_i,
    output logic [0:DW-1] diff_o,
    output logic [0:3]    neg_o
);
    logic           m9, m18, b_c;
    logic [LW9:0]   t;
    logic [0:3]     br;
    assign m9  = mode_i == MODE_4X9;
    assign m18 = mode_i == MODE_2X18;
    always_comb begin
        b_c    = 1'b0;
        t      = '0;
        br     = '0;
        diff_o = '0;
        // Chunk 3 is least significant; the borrow ripples toward chunk 0 unless a lane starts there.
        for (int c = 3; c >= 0; c--) begin
            b_c = (c == 3 || m9 || (m18 && c == 1)) ? 1'b0 : b_c;
            t = {1'b0, a_i[c*LW9 +: LW9]} - {1'b0, b_i[c*LW9 +: LW9]} - (LW9+1)'(b_c);
            diff_o[c*LW9 +: LW9] = t[LW9-1:0];
            br[c] = t[LW9];
            b_c = t[LW9];
        end
        neg_o[0] = br[0] & ~a_top_i[0];
        neg_o[1] = m9 ? br[1] & ~a_top_i[1] : m18 ? br[2] & ~a_top_i[1] : 1'b0;
        neg_o[2] = m9 & br[2] & ~a_top_i[2];
        neg_o[3] = m9 & br[3] & ~a_top_i[3];
    end
endmodule

// File: rtl/div_36x36_frac.sv
// div_36x36_frac: restoring divider, one quotient bit per clock, fracturable as 4x9, 2x18 or 1x36.
module div_36x36_frac
    import div_frac_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [0:1]    mode_i,
    input  logic [0:DW-1] dividend_i,
    input  logic [0:DW-1] divisor_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic [0:DW-1] quotient_o,
    output logic [0:DW-1] remainder_o,
    output logic [0:3]    div_by_zero_o,
    output logic          out_valid_o,
    input  logic          out_ready_i
);
    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [0:DW-1] r_q, r_d, q_q, q_d, d_q, d_d;
    logic [0:DW-1] r_sh, q_top, diff, r_nx, q_nx;
    logic [0:3]    dz_q, dz_d, dz_in, top, neg;
    logic          m9, m18, i9, i18;
    assign m9  = mode_q == MODE_4X9;
    assign m18 = mode_q == MODE_2X18;
    assign i9  = mode_i == MODE_4X9;
    assign i18 = mode_i == MODE_2X18;
    // Per-lane left shift of {R,Q}: each lane's Q MSB drops into the same lane's R LSB.
    always_comb begin
        q_top = m9 ? q_q >> (LW9 - 1) : m18 ? q_q >> (LW18 - 1) : q_q >> (DW - 1);
        r_sh  = r_q << 1;
        for (int i = 0; i < DW; i++)
            r_sh[i] = is_lsb(mode_q, i) ? q_top[i] : r_sh[i];
        top = {r_q[0], m9 ? r_q[LW9] : m18 ? r_q[LW18] : 1'b0, m9 & r_q[2*LW9], m9 & r_q[3*LW9]};
    end
    frac_sub_36 u_sub (
        .mode_i  (mode_q),
        .a_i     (r_sh),
        .a_top_i (top),
        .b_i     (d_q),
        .diff_o  (diff),
        .neg_o   (neg)
    );
    always_comb begin
        r_nx = r_sh;
        q_nx = q_q << 1;
        for (int i = 0; i < DW; i++) begin
            r_nx[i] = neg[lane_of(mode_q, i)] ? r_sh[i] : diff[i];
            q_nx[i] = is_lsb(mode_q, i) ? ~neg[lane_of(mode_q, i)] : q_nx[i];
        end
    end
    always_comb begin
        dz_in[0] = i9 ? divisor_i[0 +: LW9] == '0 : i18 ? divisor_i[0 +: LW18] == '0 : divisor_i == '0;
        dz_in[1] = i9 ? divisor_i[LW9 +: LW9] == '0 : i18 ? divisor_i[LW18 +: LW18] == '0 : 1'b0;
        dz_in[2] = i9 && divisor_i[2*LW9 +: LW9] == '0;
        dz_in[3] = i9 && divisor_i[3*LW9 +: LW9] == '0;
    end
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (in_valid_i) begin
                state_d = BUSY;
                mode_d  = mode_i;
                cnt_d   = iter_count(mode_i);
                r_d     = '0;
                q_d     = dividend_i;
                d_d     = divisor_i;
                dz_d    = dz_in;
            end
            BUSY: begin
                state_d = (cnt_q == 6'd1) ? DONE : BUSY;
                cnt_d   = cnt_q - 6'd1;
                r_d     = r_nx;
                q_d     = q_nx;
            end
            DONE: state_d = out_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            dz_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            dz_q    <= dz_d;
        end
    end
    assign in_ready_o    = rst_n && state_q == IDLE;
    assign out_valid_o   = state_q == DONE;
    assign quotient_o    = q_q;
    assign remainder_o   = r_q;
    assign div_by_zero_o = dz_q;
endmodule

// File: tb/tb_div_36x36_frac.sv
// tb_div_36x36_frac: directed checks of the fracturable divider in every mode, with backpressure and reset.
module tb_div_36x36_frac;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:1]  mode;
    logic [0:35] dividend, divisor, quotient, remainder;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [0:3]  div_by_zero;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    div_36x36_frac dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode_i        (mode),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (div_by_zero),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready)
    );

    // Launch one operation and count edges until out_valid; operands are scrambled after accept.
    task automatic start_op(input logic [1:0] m, input logic [35:0] a, input logic [35:0] b, output int lat);
        mode = m; dividend = a; divisor = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; mode = ~m; dividend = 36'h5A5A5A5A5; divisor = 36'h0000000F3;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic pop;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (quotient !== 36'd0) begin fails++; $display("FAIL reset_quotient got %0d want 0", quotient); end
        tests++; if (remainder !== 36'd0) begin fails++; $display("FAIL reset_remainder got %0d want 0", remainder); end
        tests++; if (div_by_zero !== 4'b0000) begin fails++; $display("FAIL reset_dbz got %b want 0000", div_by_zero); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready_low got %b want 0", in_ready); end
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_release got %b want 1", in_ready); end
    endtask

    task automatic test_1x36;
        int lat;
        start_op(2'b00, 36'd1000, 36'd7, lat);
        tests++; if (lat !== 36) begin fails++; $display("FAIL x36_latency got %0d want 36", lat); end
        tests++; if (quotient !== 36'd142) begin fails++; $display("FAIL x36_quotient got %0d want 142", quotient); end
        tests++; if (remainder !== 36'd6) begin fails++; $display("FAIL x36_remainder got %0d want 6", remainder); end
        tests++; if (div_by_zero !== 4'b0000) begin fails++; $display("FAIL x36_dbz got %b want 0000", div_by_zero); end
        pop();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL x36_pop got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    endtask

    task automatic test_4x9;
        int lat;
        start_op(2'b01, {9'd200, 9'd255, 9'd7, 9'd0}, {9'd10, 9'd1, 9'd0, 9'd5}, lat);
        tests++; if (lat !== 9) begin fails++; $display("FAIL x9_latency got %0d want 9", lat); end
        tests++; if (quotient !== {9'd20, 9'd255, 9'd511, 9'd0}) begin fails++; $display("FAIL x9_quotient got %h want %h", quotient, {9'd20, 9'd255, 9'd511, 9'd0}); end
        tests++; if (remainder !== {9'd0, 9'd0, 9'd7, 9'd0}) begin fails++; $display("FAIL x9_remainder got %h want %h", remainder, {9'd0, 9'd0, 9'd7, 9'd0}); end
        tests++; if (div_by_zero !== 4'b0010) begin fails++; $display("FAIL x9_dbz got %b want 0010", div_by_zero); end
        pop();
    endtask

    task automatic test_2x18;
        int lat;
        start_op(2'b10, {18'd262143, 18'd100000}, {18'd3, 18'd333}, lat);
        tests++; if (lat !== 18) begin fails++; $display("FAIL x18_latency got %0d want 18", lat); end
        tests++; if (quotient !== {18'd87381, 18'd300}) begin fails++; $display("FAIL x18_quotient got %h want %h", quotient, {18'd87381, 18'd300}); end
        tests++; if (remainder !== {18'd0, 18'd100}) begin fails++; $display("FAIL x18_remainder got %h want %h", remainder, {18'd0, 18'd100}); end
        tests++; if (div_by_zero !== 4'b0000) begin fails++; $display("FAIL x18_dbz got %b want 0000", div_by_zero); end
        pop();
    endtask

    task automatic test_mode11;
        int lat;
        start_op(2'b11, 36'd1000, 36'd7, lat);
        tests++; if (lat !== 36) begin fails++; $display("FAIL m11_latency got %0d want 36", lat); end
        tests++; if (quotient !== 36'd142 || remainder !== 36'd6) begin fails++; $display("FAIL m11_result got %0d r%0d want 142 r6", quotient, remainder); end
        pop();
    endtask

    task automatic test_div_zero_36;
        int lat;
        start_op(2'b00, 36'd5, 36'd0, lat);
        tests++; if (lat !== 36) begin fails++; $display("FAIL dz36_latency got %0d want 36", lat); end
        tests++; if (quotient !== 36'hFFFFFFFFF) begin fails++; $display("FAIL dz36_quotient got %h want fffffffff", quotient); end
        tests++; if (remainder !== 36'd5) begin fails++; $display("FAIL dz36_remainder got %0d want 5", remainder); end
        tests++; if (div_by_zero !== 4'b1000) begin fails++; $display("FAIL dz36_dbz got %b want 1000", div_by_zero); end
        pop();
    endtask

    task automatic test_backpressure;
        int lat;
        start_op(2'b00, 36'd123456789, 36'd1000, lat);
        tests++; if (lat !== 36) begin fails++; $display("FAIL bp_latency got %0d want 36", lat); end
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; mode = 2'b01; dividend = 36'd77; divisor = 36'd3;
            @(posedge clk); #1;
            tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_%0d got v=%b r=%b want v=1 r=0", k, out_valid, in_ready); end
            tests++; if (quotient !== 36'd123456 || remainder !== 36'd789) begin fails++; $display("FAIL bp_stable_%0d got %0d r%0d want 123456 r789", k, quotient, remainder); end
        end
        in_valid = 1'b0;
        pop();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid_op;
        int lat;
        bit seen;
        mode = 2'b00; dividend = 36'd123456; divisor = 36'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++; if (quotient !== 36'd0 || remainder !== 36'd0 || div_by_zero !== 4'b0000) begin fails++; $display("FAIL abort_outputs got q=%0d r=%0d dz=%b want 0", quotient, remainder, div_by_zero); end
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL abort_handshake got v=%b r=%b want 0 0", out_valid, in_ready); end
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_result got %b want 0", seen); end
        start_op(2'b00, 36'd1000, 36'd7, lat);
        tests++; if (lat !== 36 || quotient !== 36'd142 || remainder !== 36'd6) begin fails++; $display("FAIL abort_rerun got lat=%0d q=%0d r=%0d want 36 142 6", lat, quotient, remainder); end
        pop();
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; mode = 2'b00; dividend = '0; divisor = '0;
        test_reset();
        test_1x36();
        test_4x9();
        test_2x18();
        test_mode11();
        test_div_zero_36();
        test_backpressure();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
